// File: rtl/prpg_pkg.sv
// Shared constants for the pseudo-random pattern generator: feedback modes,
// maximal-length tap masks (Fibonacci and Galois forms) and the count width.
package prpg_pkg;

    localparam logic PRPG_FIB = 1'b0;
    localparam logic PRPG_GAL = 1'b1;

    // Galois masks toggle on the shifted-out bit, so bit N-1 is always set.
    // The Fibonacci mask of the same polynomial is bit 0 plus the Galois
    // mask (without bit N-1) shifted up by one.
    localparam logic [3:0]  PRPG_FIB_TAPS_4  = 4'h3;
    localparam logic [3:0]  PRPG_GAL_TAPS_4  = 4'h9;
    localparam logic [7:0]  PRPG_FIB_TAPS_8  = 8'h71;
    localparam logic [7:0]  PRPG_GAL_TAPS_8  = 8'hB8;
    localparam logic [15:0] PRPG_FIB_TAPS_16 = 16'h6801;
    localparam logic [15:0] PRPG_GAL_TAPS_16 = 16'hB400;
    localparam logic [31:0] PRPG_FIB_TAPS_32 = 32'h0040_0007;
    localparam logic [31:0] PRPG_GAL_TAPS_32 = 32'h8020_0003;

    function automatic int prpg_cw(input int win_len);
        return $clog2(win_len + 1);
    endfunction

endpackage

// File: rtl/prpg_window_stat.sv
// Window statistics: counts ones of the serial stream over WIN_LEN enabled
// cycles and publishes the total of each completed window with a valid pulse.
module prpg_window_stat
    import prpg_pkg::*;
#(
    parameter int WIN_LEN = 15,
    parameter int CW      = prpg_cw(WIN_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          enable,
    input  logic          sbit,
    output logic [CW-1:0] count,
    output logic [CW-1:0] num,
    output logic          valid
);

    localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

    logic [CW-1:0] wcnt;
    logic [CW-1:0] sum;

    assign sum = count + CW'(sbit);

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt  <= '0;
            count <= '0;
            num   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            wcnt  <= '0;
            count <= '0;
            num   <= '0;
            valid <= 1'b0;
        end else if (enable) begin
            if (wcnt == LAST) begin
                // the last bit of the window belongs to the reported total
                num   <= sum;
                count <= '0;
                wcnt  <= '0;
                valid <= 1'b1;
            end else begin
                count <= sum;
                wcnt  <= wcnt + 1'b1;
                valid <= 1'b0;
            end
        end else begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lfsr_prpg_gen.sv
// N-bit Fibonacci/Galois PRPG with seed load, window stats and period detect.
// Define PRPG_ZERO_GUARD_EN to replace a zero seed/state with 1 (no lock-up).
module lfsr_prpg_gen
    import prpg_pkg::*;
#(
    parameter int           N        = 4,
    parameter logic [N-1:0] FIB_TAPS = PRPG_FIB_TAPS_4[N-1:0],
    parameter logic [N-1:0] GAL_TAPS = PRPG_GAL_TAPS_4[N-1:0],
    parameter int           WIN_LEN  = (1 << N) - 1,
    parameter int           CW       = prpg_cw(WIN_LEN)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [N-1:0]  seed,
    input  logic          mode,
    input  logic          enable,
    output logic [N-1:0]  state,
    output logic          serial,
    output logic [CW-1:0] count,
    output logic [CW-1:0] num,
    output logic          valid,
    output logic          period_done
);

    logic [N-1:0] seed_q;
    logic [N-1:0] seed_eff;
    logic [N-1:0] nxt;
    logic         mode_q;

    always_comb begin
        seed_eff = seed;
`ifdef PRPG_ZERO_GUARD_EN
        if (seed == '0) seed_eff = N'(1);
`endif
    end

    always_comb begin
        nxt = state;
        if (mode_q == PRPG_GAL) begin
            nxt = {1'b0, state[N-1:1]} ^ ({N{state[0]}} & GAL_TAPS);
        end else begin
            nxt = {^(state & FIB_TAPS), state[N-1:1]};
        end
`ifdef PRPG_ZERO_GUARD_EN
        // the zero state is only reachable through reset; leave it at once
        if (state == '0) nxt = N'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= '0;
            seed_q      <= '0;
            mode_q      <= PRPG_FIB;
            period_done <= 1'b0;
        end else if (load) begin
            state       <= seed_eff;
            seed_q      <= seed_eff;
            mode_q      <= mode;
            period_done <= 1'b0;
        end else if (enable) begin
            state       <= nxt;
            period_done <= (nxt == seed_q);
        end else begin
            period_done <= 1'b0;
        end
    end

    assign serial = state[0];

    prpg_window_stat #(
        .WIN_LEN (WIN_LEN),
        .CW      (CW)
    ) u_stat (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .enable (enable),
        .sbit   (serial),
        .count  (count),
        .num    (num),
        .valid  (valid)
    );

endmodule

// File: tb/tb_lfsr_prpg_gen.sv
// Directed bench for lfsr_prpg_gen (N=4, WIN_LEN=15) against hand-derived
// state tables for both feedback modes.
module tb_lfsr_prpg_gen;

    import prpg_pkg::*;

    localparam int N  = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          load;
    logic [N-1:0]  seed;
    logic          mode;
    logic          enable;
    logic [N-1:0]  state;
    logic          serial;
    logic [CW-1:0] count;
    logic [CW-1:0] num;
    logic          valid;
    logic          period_done;

    int total = 0;
    int bad   = 0;

    logic [3:0] fib_tab [15] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB,
                                 4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3,
                                 4'h1};
    logic [3:0] gal_tab [15] = '{4'h1, 4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA,
                                 4'h5, 4'hB, 4'hC, 4'h6, 4'h3, 4'h8, 4'h4,
                                 4'h2};

    always #5 clk = ~clk;

    lfsr_prpg_gen #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .seed        (seed),
        .mode        (mode),
        .enable      (enable),
        .state       (state),
        .serial      (serial),
        .count       (count),
        .num         (num),
        .valid       (valid),
        .period_done (period_done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] tab(input logic m, input int i);
        return m ? gal_tab[i % 15] : fib_tab[i % 15];
    endfunction

    task automatic do_load(input logic [3:0] s, input logic m);
        load   = 1'b1;
        seed   = s;
        mode   = m;
        enable = 1'b0;
        step;
        load   = 1'b0;
    endtask

    task automatic run_period(input string tag, input logic m, input int i0);
        int ones = 0;
        int idx  = i0;
        logic [3:0] cur;
        enable = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cur  = tab(m, idx);
            ones += int'(cur[0]);
            idx++;
            step;
            chk({tag, "_state"}, 32'(state), 32'(tab(m, idx)));
            chk({tag, "_valid"}, 32'(valid), 32'(k == 15));
            chk({tag, "_pdone"}, 32'(period_done), 32'(k == 15));
            chk({tag, "_count"}, 32'(count), (k == 15) ? 0 : 32'(ones));
        end
        chk({tag, "_num"}, 32'(num), 32'd8);
        enable = 1'b0;
    endtask

    initial begin
        int idx;
        int en_cnt;
        int ones;
        logic [3:0] cur;

        reset  = 1'b1;
        load   = 1'b0;
        enable = 1'b0;
        seed   = '0;
        mode   = 1'b0;
        step;
        step;
        chk("rst_state", 32'(state), 0);
        chk("rst_serial", 32'(serial), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_num", 32'(num), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pdone", 32'(period_done), 0);
        reset = 1'b0;

        do_load(4'h8, PRPG_FIB);
        chk("fib_seed", 32'(state), 32'h8);
        chk("fib_serial0", 32'(serial), 0);
        run_period("fib", PRPG_FIB, 0);

        do_load(4'h1, PRPG_GAL);
        chk("gal_seed", 32'(state), 32'h1);
        chk("gal_serial0", 32'(serial), 1);
        run_period("gal", PRPG_GAL, 0);

        // enable toggled 1010...: valid every 30 cycles, holds in between
        do_load(4'h8, PRPG_FIB);
        idx    = 0;
        en_cnt = 0;
        ones   = 0;
        for (int s = 1; s <= 60; s++) begin
            enable = (s % 2 == 1);
            if (enable) begin
                cur  = tab(PRPG_FIB, idx);
                ones += int'(cur[0]);
                idx++;
                en_cnt++;
                if (en_cnt % 15 == 0) ones = 0;
            end
            step;
            chk("tog_state", 32'(state), 32'(tab(PRPG_FIB, idx)));
            chk("tog_count", 32'(count), 32'(ones));
            chk("tog_valid", 32'(valid),
                32'(enable && (en_cnt % 15 == 0)));
            if (enable && (en_cnt % 15 == 0))
                chk("tog_num", 32'(num), 32'd8);
        end
        enable = 1'b0;

        // load in mid-window discards the partial count
        do_load(4'h8, PRPG_FIB);
        enable = 1'b1;
        repeat (7) step;
        chk("mid_count7", 32'(count), 32'd2);
        load = 1'b1;
        seed = 4'h6;
        mode = PRPG_FIB;
        step;
        load = 1'b0;
        chk("mid_state", 32'(state), 32'h6);
        chk("mid_count", 32'(count), 0);
        chk("mid_valid", 32'(valid), 0);
        run_period("mid", PRPG_FIB, 5);

        // load coinciding with the window end suppresses valid
        do_load(4'h8, PRPG_FIB);
        enable = 1'b1;
        repeat (14) step;
        chk("end_pre_valid", 32'(valid), 0);
        load = 1'b1;
        seed = 4'h8;
        step;
        load   = 1'b0;
        enable = 1'b0;
        chk("end_valid", 32'(valid), 0);
        chk("end_num", 32'(num), 0);
        chk("end_count", 32'(count), 0);
        chk("end_state", 32'(state), 32'h8);

        do_load(4'h0, PRPG_FIB);
`ifdef PRPG_ZERO_GUARD_EN
        chk("zero_state", 32'(state), 32'h1);
        run_period("zero", PRPG_FIB, 14);
`else
        chk("zero_state", 32'(state), 0);
        enable = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step;
            chk("zero_hold", 32'(state), 0);
            chk("zero_serial", 32'(serial), 0);
            chk("zero_pdone", 32'(period_done), 1);
            chk("zero_valid", 32'(valid), 32'(k == 15));
        end
        chk("zero_num", 32'(num), 0);
        do_load(4'h0, PRPG_GAL);
        enable = 1'b1;
        repeat (3) begin
            step;
            chk("zero_gal", 32'(state), 0);
            chk("zero_gal_pd", 32'(period_done), 1);
        end
        enable = 1'b0;
`endif

        // reset mid-window clears everything and returns to Fibonacci
        do_load(4'h1, PRPG_GAL);
        enable = 1'b1;
        repeat (5) step;
        reset = 1'b1;
        step;
        reset  = 1'b0;
        enable = 1'b0;
        chk("mrst_state", 32'(state), 0);
        chk("mrst_count", 32'(count), 0);
        chk("mrst_num", 32'(num), 0);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_pdone", 32'(period_done), 0);
        chk("mrst_mode", 32'(dut.mode_q), 0);
        repeat (3) begin
            step;
            chk("mrst_idle_valid", 32'(valid), 0);
        end
        do_load(4'h8, PRPG_FIB);
        run_period("post", PRPG_FIB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_prpg_gen.md
# lfsr_prpg_gen

Parametrised pseudo-random pattern generator: an N-bit LFSR with Fibonacci or Galois feedback and run-time seed load. It includes a window statistics unit that counts ones in the serial output over a configurable window, and a period-completion detector. It is the next-generation PRPG for BIST and stimulus generation, replacing the fixed-tap, fixed-window generator in the pattern-generation path.

## Interface
Parameters:
- N, 4, LFSR width; legal 4..32.
- FIB_TAPS, 4'b0011, Fibonacci tap mask; bit i set means state[i] is XORed into nextbit.
- GAL_TAPS, 4'b1001, Galois toggle mask.
- WIN_LEN, 2**N-1, window length in enabled cycles; must be ≥2.
- CW, $clog2(WIN_LEN+1), count width (derived).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- load  in  1  load seed and mode; clear statistics.
- seed  in  N  seed value.
- mode  in  1  0 = Fibonacci, 1 = Galois; sampled only when load=1.
- enable  in  1  advance LFSR and window when high.
- state  out  N  current LFSR state.
- sequence  out  1  serial output, equal to state[0].
- count  out  CW  running ones count in the current window.
- num  out  CW  ones count of the last completed window.
- valid  out  1  one-cycle pulse; num updated this cycle.
- period_done  out  1  one-cycle pulse when state returns to the loaded seed.

## Operation
- Priority: reset > load > enable.
- reset=1: state, seed_q, mode_q, wcnt, count, num, valid and period_done all go to 0.
- load=1: state <= seed, seed_q <= seed, mode_q <= mode, wcnt/count/num <= 0, valid/period_done <= 0.
- enable=1 with mode_q=0 (Fibonacci): nextbit = ^(state & FIB_TAPS); state <= {nextbit, state[N-1:1]}.
- enable=1 with mode_q=1 (Galois): state <= {1'b0, state[N-1:1]} ^ ({N{state[0]}} & GAL_TAPS).
- Window counter wcnt runs 0..WIN_LEN-1 and advances only on enabled cycles.
  - If wcnt < WIN_LEN-1: count += sequence; wcnt++.
  - If wcnt == WIN_LEN-1: num <= count + sequence (the final bit is included); count <= 0; wcnt <= 0; valid <= 1.
- period_done <= 1 on an enabled cycle where the next state == seed_q.
- enable=0: state, wcnt and count hold; valid and period_done are 0.
- An all-zero state is a lock-up state. Its behaviour is defined under Configuration.

## Timing
- Every output is registered except sequence, which equals state[0].
- Load at cycle L: state == seed at L+1, and sequence == seed[0] at L+1.
- That first bit is counted at the first enabled edge after L.
- With continuous enable from L+1, valid is high in cycle L+WIN_LEN+1, and again every WIN_LEN cycles after that.
- With continuous enable, period_done is high in cycle L+P+1, where P is the LFSR period; it then repeats every P cycles.
- load asserted mid-window discards the partial count.
- load in the same cycle as a window end: load wins, and no valid pulse is produced.
- reset mid-operation: all state clears on that edge. mode_q returns to Fibonacci.

## Configuration
- PRPG_ZERO_GUARD_EN defined:
  - A load with seed == 0 loads state = 1 and seed_q = 1.
  - The LFSR never locks up.
- PRPG_ZERO_GUARD_EN undefined:
  - A zero seed loads 0, and state stays 0 (both feedback modes).
  - sequence stays 0, and each completed window reports num = 0.
  - period_done pulses on every enabled cycle.

## Structure
- Package prpg_pkg holds:
  - the mode constants PRPG_FIB = 1'b0 and PRPG_GAL = 1'b1;
  - default maximal-length tap constants for N = 4, 8, 16 and 32 in both Fibonacci and Galois form;
  - a function computing CW.
- Sub-module prpg_window_stat (params WIN_LEN, CW) holds wcnt, count, num and valid. Its inputs are bit, enable, load and reset.
- The top level holds the LFSR, seed_q, mode_q and the period detector.

## Test plan
- Fibonacci, N=4, seed 4'b1000, continuous enable → state sequence 1000, 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111, 0111, 0011, 0001; period_done at L+16; valid at L+16 with num=8.
- Galois, N=4, seed 4'b0001 → sequence 0001, 1001, 1101, 1111, 1110, 0111, 1010, 0101, 1011, 1100, 0110, 0011, 1000, 0100, 0010; period 15; num=8.
- Window test: enable toggled 1010… after load → valid every 30 cycles; state and count hold in disabled cycles; num=8.
- Mid-window load with seed 4'b0110 at window position 7 → count cleared; next valid arrives 15 enabled cycles later.
- Zero seed → with PRPG_ZERO_GUARD_EN: state=0001 and a period of 15. Without it: state stays 0, num=0, and period_done pulses every enabled cycle.
- reset asserted mid-window, then released → all outputs 0; mode_q returns to Fibonacci; no valid until after a fresh load.
